// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 scan-byte sequencer.
package kbd_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_EE = 8'hEE;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    localparam int EVT_W = 14;

    typedef struct packed {
        logic       rpt;
        logic       caps;
        logic       ctrl;
        logic       shift;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_POP,
        ST_WAIT
    } pop_state_t;

    // Bytes that carry no key information (BAT result, ACK, resend, echo, errors).
    function automatic logic is_filler(input logic [7:0] b);
        return (b == BYTE_E1) || (b == BYTE_AA) || (b == BYTE_FA) ||
               (b == BYTE_FE) || (b == BYTE_EE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO; head word reads as zero while empty.
module kbd_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Pops PS/2 receiver bytes, strips E0/F0 prefixes, tracks modifiers and queues key events.
//   state      | meaning
//   ST_IDLE    | wait for a byte and a free queue slot; latch rx_data
//   ST_CAPTURE | decode latched byte, update prefix/modifier/repeat state
//   ST_POP     | rx_nextdata_n low; event written on the closing edge
//   ST_WAIT    | let rx_ready reflect the pop
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int EVT_DEPTH   = 4,
    parameter int DROP_REPEAT = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_overflow,
    output logic       rx_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic       evt_shift,
    output logic       evt_ctrl,
    output logic       evt_caps,
    output logic       err_ovf,
    input  logic       err_clr
);
    pop_state_t state_q, state_d;
    logic [7:0] byte_q;
    logic       load;

    logic       ext_pend_q, brk_pend_q;
    logic       shift_l_q, shift_r_q, ctrl_l_q, ctrl_r_q, caps_q;
    logic [8:0] last_make_q;
    kbd_evt_t   evt_q;
    logic       push_pend_q;
    logic       ovf_q;
    logic       ovf_rise;

    logic       ext_pend_d, brk_pend_d;
    logic       shift_l_d, shift_r_d, ctrl_l_d, ctrl_r_d, caps_d;
    logic [8:0] last_make_d;
    logic [8:0] key;
    logic       is_make, is_rep, push_d;
    kbd_evt_t   evt_d;

    logic       fifo_full, fifo_empty, fifo_push;
    kbd_evt_t   head;

    assign ovf_rise = rx_overflow && !ovf_q;

    always_comb begin
        state_d       = state_q;
        rx_nextdata_n = 1'b1;
        load          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_ready && !fifo_full) begin
                    state_d = ST_CAPTURE;
                    load    = 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_POP;
            ST_POP: begin
                rx_nextdata_n = 1'b0;
                state_d       = ST_WAIT;
            end
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        ctrl_l_d    = ctrl_l_q;
        ctrl_r_d    = ctrl_r_q;
        caps_d      = caps_q;
        last_make_d = last_make_q;
        push_d      = 1'b0;
        evt_d       = '0;
        key         = {ext_pend_q, byte_q};
        is_make     = !brk_pend_q;
        is_rep      = is_make && (key == last_make_q);

        if (byte_q == BYTE_E0) begin
            ext_pend_d = 1'b1;
        end else if (byte_q == BYTE_F0) begin
            brk_pend_d = 1'b1;
        end else begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            // A dropped repeat leaves every piece of key state untouched.
            if (!is_filler(byte_q) && !(is_rep && DROP_REPEAT != 0)) begin
                push_d = 1'b1;
                case (byte_q)
                    CODE_LSHIFT: shift_l_d = is_make;
                    CODE_RSHIFT: shift_r_d = is_make;
                    CODE_CTRL: begin
                        if (ext_pend_q) ctrl_r_d = is_make;
                        else            ctrl_l_d = is_make;
                    end
                    CODE_CAPS: begin
                        if (is_make && !is_rep) caps_d = !caps_q;
                    end
                    default: ;
                endcase
                if (is_make && !is_rep)
                    last_make_d = key;
                else if (!is_make && (key == last_make_q))
                    last_make_d = '0;
                evt_d.rpt   = is_rep;
                evt_d.caps  = caps_d;
                evt_d.ctrl  = ctrl_l_d | ctrl_r_d;
                evt_d.shift = shift_l_d | shift_r_d;
                evt_d.brk   = !is_make;
                evt_d.ext   = ext_pend_q;
                evt_d.code  = byte_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            byte_q      <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            ctrl_l_q    <= 1'b0;
            ctrl_r_q    <= 1'b0;
            caps_q      <= 1'b0;
            last_make_q <= '0;
            evt_q       <= '0;
            push_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= rx_overflow;
            if (load) byte_q <= rx_data;
            if (state_q == ST_CAPTURE) begin
                ext_pend_q  <= ext_pend_d;
                brk_pend_q  <= brk_pend_d;
                shift_l_q   <= shift_l_d;
                shift_r_q   <= shift_r_d;
                ctrl_l_q    <= ctrl_l_d;
                ctrl_r_q    <= ctrl_r_d;
                caps_q      <= caps_d;
                last_make_q <= last_make_d;
                evt_q       <= evt_d;
                push_pend_q <= push_d;
            end
            // Lost bytes make the prefix and repeat context untrustworthy; modifiers survive.
            if (ovf_rise) begin
                ext_pend_q  <= 1'b0;
                brk_pend_q  <= 1'b0;
                last_make_q <= '0;
            end
            if (err_clr)       err_ovf <= 1'b0;
            else if (ovf_rise) err_ovf <= 1'b1;
        end
    end

    assign fifo_push = (state_q == ST_POP) && push_pend_q;

    kbd_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (fifo_push),
        .wr_data (evt_q),
        .pop     (evt_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_break  = head.brk;
    assign evt_repeat = head.rpt;
    assign evt_shift  = head.shift;
    assign evt_ctrl   = head.ctrl;
    assign evt_caps   = head.caps;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: a key-event model fed from the byte stream, checked against
// two DUT instances (repeats dropped / repeats emitted) sharing one receiver model.
module tb_kbd_scan_ctrl;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_overflow = 1'b0;
    logic       evt_ready = 1'b1;
    logic       err_clr = 1'b0;

    logic       rx_nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, evt_shift, evt_ctrl, evt_caps, err_ovf;
    logic [7:0] evt_code;
    logic       rx_nextdata_n_r, evt_valid_r, evt_ext_r, evt_break_r, evt_repeat_r, evt_shift_r, evt_ctrl_r, evt_caps_r, err_ovf_r;
    logic [7:0] evt_code_r;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rx_q[$];
    logic [13:0] exp0[$], exp1[$], log0[$], log1[$];
    int          pulses = 0, bytes_sent = 0, low_run = 0;

    bit m_ext = 0, m_brk = 0, m_caps = 0;
    int m_last = 0;
    bit held[int];

    kbd_scan_ctrl #(.EVT_DEPTH(4), .DROP_REPEAT(1)) dut (
        .clk(clk), .clr(clr), .rx_data(rx_data), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
        .rx_nextdata_n(rx_nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
        .evt_shift(evt_shift), .evt_ctrl(evt_ctrl), .evt_caps(evt_caps),
        .err_ovf(err_ovf), .err_clr(err_clr)
    );

    kbd_scan_ctrl #(.EVT_DEPTH(4), .DROP_REPEAT(0)) dut_r (
        .clk(clk), .clr(clr), .rx_data(rx_data), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
        .rx_nextdata_n(rx_nextdata_n_r), .evt_valid(evt_valid_r), .evt_ready(evt_ready),
        .evt_code(evt_code_r), .evt_ext(evt_ext_r), .evt_break(evt_break_r), .evt_repeat(evt_repeat_r),
        .evt_shift(evt_shift_r), .evt_ctrl(evt_ctrl_r), .evt_caps(evt_caps_r),
        .err_ovf(err_ovf_r), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Key-level model: held keys as a set, modifiers derived from membership.
    function automatic void model_byte(input logic [7:0] b);
        int key;
        bit make, rep, sh, ct;
        logic [13:0] ev;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            key  = (m_ext ? 256 : 0) + int'(b);
            make = !m_brk;
            rep  = make && (key == m_last);
            if (make) held[key] = 1;
            else if (held.exists(key)) held.delete(key);
            if (make && !rep && b == 8'h58) m_caps = !m_caps;
            if (make && !rep) m_last = key;
            else if (!make && key == m_last) m_last = 0;
            sh = held.exists('h12) || held.exists('h112) || held.exists('h59) || held.exists('h159);
            ct = held.exists('h14) || held.exists('h114);
            ev = {rep, m_caps, ct, sh, !make, m_ext, b};
            exp1.push_back(ev);
            if (!rep) exp0.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic void model_ovf();
        m_ext = 0;
        m_brk = 0;
        m_last = 0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_q.push_back(b);
        model_byte(b);
        bytes_sent++;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((rx_q.size() != 0 || exp0.size() != 0 || exp1.size() != 0 || evt_valid || evt_valid_r) && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        chk("quiet_timeout", 32'(n < 400), 1);
        repeat (6) @(posedge clk);
        #2;
    endtask

    // Receiver model: pops its head on each low cycle of rx_nextdata_n.
    initial forever begin
        @(negedge clk);
        if (!rx_nextdata_n) begin
            low_run++;
            chk("pop_width", low_run, 1);
            if (low_run == 1) begin
                pulses++;
                chk("pop_nonempty", 32'(rx_q.size() != 0), 1);
                if (rx_q.size() != 0) void'(rx_q.pop_front());
            end
        end else begin
            low_run = 0;
        end
        rx_ready = (rx_q.size() != 0);
        rx_data  = rx_ready ? rx_q[0] : 8'h00;
    end

    initial forever begin
        logic [13:0] cur;
        @(negedge clk);
        if (!clr && evt_valid) begin
            cur = {evt_repeat, evt_caps, evt_ctrl, evt_shift, evt_break, evt_ext, evt_code};
            if (exp0.size() == 0) chk("evt0_expected_pending", exp0.size(), 1);
            else begin
                chk("evt0_head", cur, exp0[0]);
                if (evt_ready) begin
                    log0.push_back(cur);
                    void'(exp0.pop_front());
                end
            end
        end
        if (!clr && evt_valid_r) begin
            cur = {evt_repeat_r, evt_caps_r, evt_ctrl_r, evt_shift_r, evt_break_r, evt_ext_r, evt_code_r};
            if (exp1.size() == 0) chk("evt1_expected_pending", exp1.size(), 1);
            else begin
                chk("evt1_head", cur, exp1[0]);
                if (evt_ready) begin
                    log1.push_back(cur);
                    void'(exp1.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, b0, b1, pb;
        logic [7:0] stall_codes [6];
        stall_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_nextdata_n", rx_nextdata_n, 1);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_fields", {evt_repeat, evt_caps, evt_ctrl, evt_shift, evt_break, evt_ext, evt_code}, 0);
        chk("rst_err_ovf", err_ovf, 0);
        clr = 1'b0;
        @(posedge clk); #2;

        // Make/break of 1C, with first-byte latency measured
        b0 = log0.size();
        send_byte(8'h1C);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!rx_ready && n < 20);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!evt_valid && n < 20);
        chk("latency_to_valid", n, 3);
        send_byte(8'hF0); send_byte(8'h1C);
        wait_quiet();
        chk("t1_count", log0.size() - b0, 2);
        chk("t1_make", log0[b0], 14'h001C);
        chk("t1_break", log0[b0+1], 14'h021C);

        // Extended key make/break
        b0 = log0.size();
        send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        wait_quiet();
        chk("t2_count", log0.size() - b0, 2);
        chk("t2_make", log0[b0], 14'h0175);
        chk("t2_break", log0[b0+1], 14'h0375);

        // Shift held across typematic repeats
        b0 = log0.size();
        b1 = log1.size();
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        wait_quiet();
        chk("t3_drop_count", log0.size() - b0, 4);
        chk("t3_keep_count", log1.size() - b1, 6);
        chk("t3_shift_make", log0[b0], 14'h0412);
        chk("t3_key_make", log0[b0+1], 14'h041C);
        chk("t3_key_break", log0[b0+2], 14'h061C);
        chk("t3_shift_break", log0[b0+3], 14'h0212);
        chk("t3_rep1", log1[b1+2], 14'h241C);
        chk("t3_rep2", log1[b1+3], 14'h241C);

        // Caps lock toggling
        b0 = log0.size();
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        wait_quiet();
        chk("t4_caps_on", log0[b0], 14'h1058);
        chk("t4_caps_on_break", log0[b0+1], 14'h1258);
        chk("t4_caps_off", log0[b0+2], 14'h0058);
        chk("t4_caps_off_break", log0[b0+3], 14'h0258);

        // Back-pressure: queue full stalls the receiver pops
        b0 = log0.size();
        pb = pulses;
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(stall_codes[i]);
        repeat (60) @(posedge clk);
        #2;
        chk("stall_pops", pulses - pb, 4);
        chk("stall_rx_left", rx_q.size(), 2);
        chk("stall_nextdata_n", rx_nextdata_n, 1);
        chk("stall_valid", evt_valid, 1);
        evt_ready = 1'b1;
        wait_quiet();
        chk("stall_drain_count", log0.size() - b0, 6);
        for (int i = 0; i < 6; i++) chk("stall_order", log0[b0+i], {6'd0, stall_codes[i]});

        // Overflow drops the pending E0 but keeps shift
        send_byte(8'h12); send_byte(8'hE0);
        wait_quiet();
        rx_overflow = 1'b1;
        @(posedge clk); #2;
        rx_overflow = 1'b0;
        model_ovf();
        chk("ovf_set", err_ovf, 1);
        b0 = log0.size();
        send_byte(8'h1C);
        wait_quiet();
        chk("ovf_next_code", log0[b0], 14'h041C);
        chk("ovf_sticky", err_ovf, 1);
        send_byte(8'hF0); send_byte(8'h12);
        wait_quiet();
        err_clr = 1'b1;
        @(posedge clk); #2;
        err_clr = 1'b0;
        chk("ovf_cleared", err_ovf, 0);
        rx_overflow = 1'b1;
        err_clr = 1'b1;
        @(posedge clk); #2;
        chk("clr_priority", err_ovf, 0);
        rx_overflow = 1'b0;
        err_clr = 1'b0;
        model_ovf();
        @(posedge clk); #2;
        chk("clr_priority_hold", err_ovf, 0);

        // Reset while rx_nextdata_n is low
        rx_q.push_back(8'h2C);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (rx_nextdata_n && n < 20);
        chk("mid_pop_reached", rx_nextdata_n, 0);
        clr = 1'b1;
        #1;
        chk("mid_pop_nextdata_n", rx_nextdata_n, 1);
        chk("mid_pop_valid", evt_valid, 0);
        @(posedge clk); #2;
        rx_q.delete();
        exp0.delete();
        exp1.delete();
        held.delete();
        model_ovf();
        m_caps = 0;
        chk("rst_edge_valid", evt_valid, 0);
        chk("rst_edge_nextdata_n", rx_nextdata_n, 1);
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("post_rst_valid", evt_valid, 0);
        b0 = log0.size();
        send_byte(8'h1C);
        wait_quiet();
        chk("post_rst_event", log0[b0], 14'h001C);

        chk("pulses_per_byte", pulses, bytes_sent);
        chk("exp0_drained", exp0.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
